// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage; EX inputs (ex_*) issue aligned dmem requests (dmem_*), hold while outstanding, register results to WB (wb_*)
module mem_stage #(
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [6:0]           ex_opcode,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_aluout,
  input  logic [31:0]          ex_rs2_v,
  input  logic [PAYLOAD_W-1:0] ex_payload,
  output logic                 ex_ready,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_resp,
  input  logic [31:0]          dmem_rdata,
  output logic                 wb_valid,
  output logic [PAYLOAD_W-1:0] wb_payload,
  output logic [31:0]          wb_aluout,
  output logic [31:0]          wb_rdata,
  output logic [1:0]           wb_addr_lo,
  output logic                 wb_misaligned
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, next_state;
  logic is_load, is_store, is_mem, aligned, accept, issue, done;
  logic [3:0] mask;
  logic [PAYLOAD_W-1:0] hold_payload;
  logic [31:0] hold_aluout;
  logic [1:0] hold_lo;
  logic hold_load;
  logic unused_sign;
  assign unused_sign = ex_funct3[2];
  assign is_load  = ex_opcode == OP_LOAD;
  assign is_store = ex_opcode == OP_STORE;
  assign is_mem   = is_load | is_store;
  assign aligned  = ex_funct3[1:0] == 2'b00 ? 1'b1 :
                    ex_funct3[1:0] == 2'b01 ? ~ex_aluout[0] :
                    ex_funct3[1:0] == 2'b10 ? ex_aluout[1:0] == 2'b00 : 1'b0;
  assign accept   = state == IDLE && ex_valid;
  assign issue    = accept && is_mem && aligned;
  assign done     = state == WAIT && dmem_resp;
  assign mask     = ex_funct3[1:0] == 2'b00 ? 4'b0001 << ex_aluout[1:0] :
                    ex_funct3[1:0] == 2'b01 ? 4'b0011 << ex_aluout[1:0] : 4'b1111;
  assign dmem_addr  = {ex_aluout[31:2], 2'b00};
  assign dmem_wdata = !is_store ? 32'd0 :
                      ex_funct3[1:0] == 2'b00 ? {4{ex_rs2_v[7:0]}} :
                      ex_funct3[1:0] == 2'b01 ? {2{ex_rs2_v[15:0]}} : ex_rs2_v;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = issue ? WAIT : IDLE;
    else next_state = dmem_resp ? IDLE : WAIT;
  end
  always_comb begin
    ex_ready   = state == IDLE;
    dmem_rmask = issue && is_load ? mask : 4'b0000;
    dmem_wmask = issue && is_store ? mask : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_payload    <= '0;
      wb_aluout     <= '0;
      wb_rdata      <= '0;
      wb_addr_lo    <= '0;
      wb_misaligned <= 1'b0;
      hold_payload  <= '0;
      hold_aluout   <= '0;
      hold_lo       <= '0;
      hold_load     <= 1'b0;
    end else begin
      wb_valid <= (accept && !issue) || done;
      if (accept && !issue) begin
        wb_payload    <= ex_payload;
        wb_aluout     <= ex_aluout;
        wb_addr_lo    <= ex_aluout[1:0];
        wb_rdata      <= '0;
        wb_misaligned <= is_mem;
      end else if (done) begin
        wb_payload    <= hold_payload;
        wb_aluout     <= hold_aluout;
        wb_addr_lo    <= hold_lo;
        wb_rdata      <= hold_load ? dmem_rdata : 32'd0;
        wb_misaligned <= 1'b0;
      end
      if (issue) begin
        hold_payload <= ex_payload;
        hold_aluout  <= ex_aluout;
        hold_lo      <= ex_aluout[1:0];
        hold_load    <= is_load;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level model and per-cycle compare
module tb_mem_stage;
  localparam int PW = 128;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011;
  logic clk = 0, rst = 1, ex_valid = 0, dmem_resp = 0;
  logic [6:0] ex_opcode = '0;
  logic [2:0] ex_funct3 = '0;
  logic [31:0] ex_aluout = '0, ex_rs2_v = '0, dmem_rdata = '0;
  logic [PW-1:0] ex_payload = '0;
  logic ex_ready, wb_valid, wb_misaligned;
  logic [31:0] dmem_addr, dmem_wdata, wb_aluout, wb_rdata;
  logic [3:0] dmem_rmask, dmem_wmask;
  logic [PW-1:0] wb_payload;
  logic [1:0] wb_addr_lo;
  int checks = 0, errors = 0;
  logic run = 0;
  mem_stage #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_aluout(ex_aluout), .ex_rs2_v(ex_rs2_v), .ex_payload(ex_payload), .ex_ready(ex_ready),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_payload(wb_payload),
    .wb_aluout(wb_aluout), .wb_rdata(wb_rdata), .wb_addr_lo(wb_addr_lo), .wb_misaligned(wb_misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int f_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic logic f_ok(logic [2:0] f3, logic [31:0] a);
    return f3[1:0] != 2'b11 && (a % f_size(f3)) == 0;
  endfunction
  function automatic logic [3:0] f_mask(logic [2:0] f3, logic [31:0] a);
    int m;
    m = ((1 << f_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction
  function automatic logic [31:0] f_wdata(logic [2:0] f3, logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % f_size(f3)) +: 8];
    return w;
  endfunction
  function automatic logic f_issue(logic busy, logic v, logic [6:0] op, logic [2:0] f3, logic [31:0] a);
    return !busy && v && (op == LD || op == ST) && f_ok(f3, a);
  endfunction
  logic m_busy = 0, h_load = 0;
  logic [PW-1:0] h_pay = '0;
  logic [31:0] h_alu = '0;
  logic e_valid = 0, e_mis = 0;
  logic [PW-1:0] e_pay = '0;
  logic [31:0] e_alu = '0, e_rdata = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 0;
      e_valid <= 0;
    end else if (!m_busy) begin
      e_valid <= ex_valid && !f_issue(0, ex_valid, ex_opcode, ex_funct3, ex_aluout);
      if (f_issue(0, ex_valid, ex_opcode, ex_funct3, ex_aluout)) begin
        m_busy <= 1;
        h_pay  <= ex_payload;
        h_alu  <= ex_aluout;
        h_load <= ex_opcode == LD;
      end else if (ex_valid) begin
        e_pay   <= ex_payload;
        e_alu   <= ex_aluout;
        e_rdata <= 0;
        e_mis   <= ex_opcode == LD || ex_opcode == ST;
      end
    end else begin
      e_valid <= dmem_resp;
      if (dmem_resp) begin
        m_busy  <= 0;
        e_pay   <= h_pay;
        e_alu   <= h_alu;
        e_rdata <= h_load ? dmem_rdata : 32'd0;
        e_mis   <= 0;
      end
    end
  end
  always @(negedge clk) if (run) begin
    logic iss;
    logic [3:0] m;
    iss = f_issue(m_busy, ex_valid, ex_opcode, ex_funct3, ex_aluout);
    m = iss ? f_mask(ex_funct3, ex_aluout) : 4'b0;
    chk("ex_ready", ex_ready, !m_busy);
    chk("rmask", dmem_rmask, ex_opcode == LD ? m : 4'b0);
    chk("wmask", dmem_wmask, ex_opcode == ST ? m : 4'b0);
    if (iss) chk("dmem_addr", dmem_addr, ex_aluout & 32'hFFFF_FFFC);
    if (iss && ex_opcode == ST) chk("wdata", dmem_wdata, f_wdata(ex_funct3, ex_rs2_v));
    chk("wb_valid", wb_valid, e_valid);
    if (e_valid) begin
      chk("wb_payload", wb_payload, e_pay);
      chk("wb_aluout", wb_aluout, e_alu);
      chk("wb_addr_lo", wb_addr_lo, e_alu[1:0]);
      chk("wb_rdata", wb_rdata, e_rdata);
      chk("wb_misaligned", wb_misaligned, e_mis);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic present(logic [6:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    ex_valid = 1; ex_opcode = op; ex_funct3 = f3; ex_aluout = a; ex_rs2_v = d;
    ex_payload = {a, ~a, d, {25'd0, op}};
  endtask
  task automatic resp_after(int k, logic [31:0] rd);
    for (int i = 1; i < k; i++) cyc();
    dmem_resp = 1; dmem_rdata = rd;
    cyc();
    dmem_resp = 0; dmem_rdata = '0;
  endtask
  logic [6:0] v_op [6] = '{ST, LD, ST, LD, ALU, LD};
  logic [2:0] v_f3 [6] = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b000, 3'b101};
  logic [31:0] v_a [6] = '{32'h10, 32'h20, 32'h31, 32'h43, 32'h55, 32'h62};
  int v_k [6] = '{2, 1, 1, 4, 1, 1};
  initial begin
    cyc(); cyc();
    rst = 0;
    run = 1;
    @(negedge clk);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_payload", wb_payload, 0);
    chk("rst wb_aluout", wb_aluout, 0);
    chk("rst wb_rdata", wb_rdata, 0);
    chk("rst wb_misaligned", wb_misaligned, 0);
    chk("rst ex_ready", ex_ready, 1);
    cyc();
    present(ALU, 3'b000, 32'h0000_1234, 32'h0);
    @(negedge clk);
    chk("alu masks", {dmem_rmask, dmem_wmask}, 0);
    cyc(); ex_valid = 0;
    @(negedge clk);
    chk("alu wb_valid", wb_valid, 1);
    chk("alu wb_aluout", wb_aluout, 32'h1234);
    chk("alu wb_rdata", wb_rdata, 0);
    cyc();
    present(LD, 3'b010, 32'h0000_1008, 32'h0);
    @(negedge clk);
    chk("lw addr", dmem_addr, 32'h1008);
    chk("lw rmask", dmem_rmask, 4'b1111);
    cyc(); ex_valid = 0;
    @(negedge clk);
    chk("lw busy", ex_ready, 0);
    resp_after(3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lw wb_valid", wb_valid, 1);
    chk("lw wb_rdata", wb_rdata, 32'hDEAD_BEEF);
    cyc();
    present(ST, 3'b000, 32'h0000_2003, 32'h0000_00A5);
    @(negedge clk);
    chk("sb wmask", dmem_wmask, 4'b1000);
    chk("sb wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb addr", dmem_addr, 32'h2000);
    cyc(); ex_valid = 0;
    resp_after(1, 32'h1234_5678);
    @(negedge clk);
    chk("sb wb_valid", wb_valid, 1);
    chk("sb wb_rdata", wb_rdata, 0);
    cyc();
    present(LD, 3'b001, 32'h0000_3001, 32'h0);
    @(negedge clk);
    chk("lh mis rmask", dmem_rmask, 0);
    cyc(); ex_valid = 0;
    @(negedge clk);
    chk("lh mis wb_valid", wb_valid, 1);
    chk("lh mis flag", wb_misaligned, 1);
    cyc();
    present(LD, 3'b010, 32'h0000_5000, 32'h0);
    cyc(); ex_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; dmem_resp = 1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rst-wait ex_ready", ex_ready, 1);
    chk("rst-wait wb_valid", wb_valid, 0);
    cyc(); dmem_resp = 0;
    @(negedge clk);
    chk("stray resp wb_valid", wb_valid, 0);
    cyc();
    present(ST, 3'b001, 32'h0000_4002, 32'h0000_BEEF);
    @(negedge clk);
    chk("sh wmask", dmem_wmask, 4'b1100);
    chk("sh wdata", dmem_wdata, 32'hBEEF_BEEF);
    cyc(); ex_valid = 0;
    resp_after(1, 32'h0);
    present(LD, 3'b100, 32'h0000_4001, 32'h0);
    @(negedge clk);
    chk("b2b sh wb_valid", wb_valid, 1);
    chk("b2b lbu rmask", dmem_rmask, 4'b0010);
    cyc(); ex_valid = 0;
    resp_after(1, 32'h0000_AB00);
    @(negedge clk);
    chk("lbu wb_rdata", wb_rdata, 32'h0000_AB00);
    chk("lbu wb_addr_lo", wb_addr_lo, 2'b01);
    cyc();
    for (int i = 0; i < 6; i++) begin
      present(v_op[i], v_f3[i], v_a[i], 32'hCAFE_BABE ^ i);
      cyc(); ex_valid = 0;
      if ((v_op[i] == LD || v_op[i] == ST) && f_ok(v_f3[i], v_a[i])) resp_after(v_k[i], 32'h600D_0000 + i);
      cyc();
    end
    present(ALU, 3'b000, 32'h77, 32'h0);
    cyc();
    present(ALU, 3'b000, 32'h88, 32'h0);
    cyc(); ex_valid = 0;
    cyc(); cyc();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
